gf_mult_seq_mode: RTL and testbench

//  Parametrised sequential multiplier. Successor to the single-mode shift-add unit.

---
 rtl/gf_mult_seq_mode.sv | 185 ++++++++++++++++++
 tb/tb_gf_mult_seq_mode.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_mult_seq_mode.sv
// Sequential W x W multiplier: D multiplier bits per cycle, MSB first, integer or carry-less mode.
// Define GF_REDUCE_EN to add in_poly and a bit-serial modular reduction pass for carry-less ops.
module gf_mult_seq_mode #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DIGIT_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    op_enable,
    input  logic                    in_mode,
    input  logic [DATA_WIDTH-1:0]   in_mult_a,
    input  logic [DATA_WIDTH-1:0]   in_mult_b,
`ifdef GF_REDUCE_EN
    input  logic [DATA_WIDTH-1:0]   in_poly,
`endif
    output logic [2*DATA_WIDTH-1:0] out_mult_result,
    output logic                    op_busy,
    output logic                    op_finish
);

    localparam int unsigned W    = DATA_WIDTH;
    localparam int unsigned D    = DIGIT_WIDTH;
    localparam int unsigned N    = W / D;
    localparam int unsigned AccW = 2 * W;
    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCalc   = 2'd1,
`ifdef GF_REDUCE_EN
        StReduce = 2'd3,
`endif
        StDone   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic              mode_q, mode_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [AccW-1:0]   res_q, res_d;

    logic [D-1:0]      digit;
    logic [AccW-1:0]   a_ext;
    logic [AccW-1:0]   acc_shift;
    logic [AccW-1:0]   int_pp;
    logic [AccW-1:0]   cl_pp;
    logic [AccW-1:0]   step_val;

`ifdef GF_REDUCE_EN
    logic [W-1:0]      poly_q, poly_d;
    logic [AccW-1:0]   red_mask;
    logic [AccW-1:0]   acc_hi_sel;
    logic              red_bit;
`endif

    // b is consumed from its top bits; shifting it left exposes the next digit each step.
    assign digit     = b_q[W-1 -: D];
    assign a_ext     = {{W{1'b0}}, a_q};
    assign acc_shift = acc_q << D;

    always_comb begin
        int_pp = '0;
        cl_pp  = '0;
        for (int unsigned j = 0; j < D; j++) begin
            if (digit[j]) begin
                int_pp = int_pp + (a_ext << j);
                cl_pp  = cl_pp ^ (a_ext << j);
            end
        end
    end

    assign step_val = mode_q ? (acc_shift ^ cl_pp) : (acc_shift + int_pp);

`ifdef GF_REDUCE_EN
    // In REDUCE, cnt selects bit W+cnt; folding it clears that bit and only touches lower ones.
    assign red_mask   = {{(W-1){1'b0}}, 1'b1, poly_q} << cnt_q;
    assign acc_hi_sel = acc_q >> cnt_q;
    assign red_bit    = acc_hi_sel[W];
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
`ifdef GF_REDUCE_EN
        poly_d  = poly_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (op_enable) begin
                    a_d     = in_mult_a;
                    b_d     = in_mult_b;
                    mode_d  = in_mode;
`ifdef GF_REDUCE_EN
                    poly_d  = in_poly;
`endif
                    acc_d   = '0;
                    cnt_d   = CntW'(N - 1);
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (!op_enable) begin
                    state_d = StIdle;
                end else begin
                    acc_d = step_val;
                    b_d   = b_q << D;
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        state_d = StDone;
                        res_d   = step_val;
`ifdef GF_REDUCE_EN
                        if (mode_q) begin
                            state_d = StReduce;
                            res_d   = res_q;
                            cnt_d   = CntW'(W - 1);
                        end
`endif
                    end
                end
            end
`ifdef GF_REDUCE_EN
            StReduce: begin
                if (!op_enable) begin
                    state_d = StIdle;
                end else begin
                    acc_d = red_bit ? (acc_q ^ red_mask) : acc_q;
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        state_d = StDone;
                        res_d   = {{W{1'b0}}, acc_d[W-1:0]};
                    end
                end
            end
`endif
            StDone: begin
                if (!op_enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
`ifdef GF_REDUCE_EN
            poly_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
`ifdef GF_REDUCE_EN
            poly_q  <= poly_d;
`endif
        end
    end

    assign out_mult_result = res_q;
    assign op_finish       = (state_q == StDone);
`ifdef GF_REDUCE_EN
    assign op_busy         = (state_q == StCalc) || (state_q == StReduce);
`else
    assign op_busy         = (state_q == StCalc);
`endif

endmodule

// File: tb/tb_gf_mult_seq_mode.sv
// Bench for gf_mult_seq_mode: three instances (32/1, 32/4, 8/1) driven from a vector table
// plus hand-written abort, reset, hold and random sequences.
module tb_gf_mult_seq_mode;

    localparam logic [31:0] POLY32 = 32'h0000_00C5;
    localparam logic [7:0]  POLY8  = 8'h1B;
`ifdef GF_REDUCE_EN
    localparam int CL1 = 64;
    localparam int CL4 = 40;
    localparam int CL8 = 16;
`else
    localparam int CL1 = 32;
    localparam int CL4 = 8;
    localparam int CL8 = 8;
`endif

    logic        clk;
    logic        rst_n;
    logic        en1, en4, en8;
    logic        mode32, mode8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic [63:0] res1, res4;
    logic [15:0] res8;
    logic        busy1, busy4, busy8;
    logic        fin1, fin4, fin8;

    int n_cmp = 0;
    int n_bad = 0;

    gf_mult_seq_mode #(.DATA_WIDTH(32), .DIGIT_WIDTH(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .op_enable(en1), .in_mode(mode32),
        .in_mult_a(a32), .in_mult_b(b32),
`ifdef GF_REDUCE_EN
        .in_poly(POLY32),
`endif
        .out_mult_result(res1), .op_busy(busy1), .op_finish(fin1)
    );

    gf_mult_seq_mode #(.DATA_WIDTH(32), .DIGIT_WIDTH(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .op_enable(en4), .in_mode(mode32),
        .in_mult_a(a32), .in_mult_b(b32),
`ifdef GF_REDUCE_EN
        .in_poly(POLY32),
`endif
        .out_mult_result(res4), .op_busy(busy4), .op_finish(fin4)
    );

    gf_mult_seq_mode #(.DATA_WIDTH(8), .DIGIT_WIDTH(1)) u_d8 (
        .clk(clk), .rst_n(rst_n), .op_enable(en8), .in_mode(mode8),
        .in_mult_a(a8), .in_mult_b(b8),
`ifdef GF_REDUCE_EN
        .in_poly(POLY8),
`endif
        .out_mult_result(res8), .op_busy(busy8), .op_finish(fin8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] clmul32(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p = '0;
        for (int i = 0; i < 32; i++) if (b[i]) p = p ^ ({32'b0, a} << i);
        return p;
    endfunction

    function automatic logic [63:0] red32(input logic [63:0] p_in, input logic [31:0] poly);
        logic [63:0] p = p_in;
        for (int i = 63; i >= 32; i--) if (p[i]) p = p ^ ({31'b0, 1'b1, poly} << (i - 32));
        return p;
    endfunction

    function automatic logic [63:0] ref32(input logic m, input logic [31:0] a, input logic [31:0] b);
        if (!m) return {32'b0, a} * {32'b0, b};
`ifdef GF_REDUCE_EN
        return red32(clmul32(a, b), POLY32);
`else
        return clmul32(a, b);
`endif
    endfunction

    function automatic logic get_fin(input int sel);
        case (sel)
            1:       return fin1;
            4:       return fin4;
            default: return fin8;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            1:       return busy1;
            4:       return busy4;
            default: return busy8;
        endcase
    endfunction

    function automatic logic [63:0] get_res(input int sel);
        case (sel)
            1:       return res1;
            4:       return res4;
            default: return {48'b0, res8};
        endcase
    endfunction

    task automatic set_en(input int sel, input logic v);
        case (sel)
            1:       en1 = v;
            4:       en4 = v;
            default: en8 = v;
        endcase
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Full handshake; operands are scrambled right after accept and must be ignored.
    task automatic run_op(input int sel, input logic m, input logic [31:0] a,
                          input logic [31:0] b, output logic [63:0] res,
                          output int cyc, output int bcnt);
        logic ok;
        @(posedge clk); #1;
        if (sel == 8) begin
            mode8 = m; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            mode32 = m; a32 = a; b32 = b;
        end
        set_en(sel, 1'b1);
        @(posedge clk); #1;
        if (sel == 8) begin
            mode8 = ~m; a8 = ~a[7:0]; b8 = ~b[7:0];
        end else begin
            mode32 = ~m; a32 = ~a; b32 = ~b;
        end
        cyc  = 0;
        bcnt = int'(get_busy(sel));
        ok   = 1'b0;
        while (cyc < 200 && !ok) begin
            @(posedge clk); #1;
            cyc++;
            bcnt += int'(get_busy(sel));
            if (get_fin(sel)) ok = 1'b1;
        end
        if (!ok) check("op_finish_timeout", 64'(ok), 64'd1);
        res = get_res(sel);
        set_en(sel, 1'b0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        int          sel;
        logic        mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          cyc;
    } vec_t;

    vec_t tv [10];

    initial begin
        logic [63:0] r;
        int          cyc, bcnt;
        logic        seen;
        logic        ok;

        tv[0] = '{1, 1'b0, 32'd3,         32'd5,         64'd15,                   32};
        tv[1] = '{4, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001,  8};
        tv[2] = '{1, 1'b1, 32'd3,         32'd3,         64'd5,                    CL1};
`ifdef GF_REDUCE_EN
        tv[3] = '{1, 1'b1, 32'h8000_0000, 32'd2,         {32'b0, POLY32},          CL1};
        tv[6] = '{8, 1'b1, 32'h57,        32'h83,        64'hC1,                   CL8};
        tv[8] = '{4, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  red32(64'h5555_5555_5555_5555, POLY32), CL4};
`else
        tv[3] = '{1, 1'b1, 32'h8000_0000, 32'd2,         64'h1_0000_0000,          CL1};
        tv[6] = '{8, 1'b1, 32'h57,        32'h83,        64'h2B79,                 CL8};
        tv[8] = '{4, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h5555_5555_5555_5555,  CL4};
`endif
        tv[4] = '{1, 1'b0, 32'd0,         32'h1234_5678, 64'd0,                    32};
        tv[5] = '{4, 1'b0, 32'h1234_5678, 32'd0,         64'd0,                    8};
        tv[7] = '{8, 1'b0, 32'h57,        32'h83,        64'h2C85,                 8};
        tv[9] = '{4, 1'b0, 32'h0001_0000, 32'h0001_0000, 64'h1_0000_0000,          8};

        rst_n = 1'b0; en1 = 1'b0; en4 = 1'b0; en8 = 1'b0;
        mode32 = 1'b0; mode8 = 1'b0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        #1;
        check("reset_result", res1, 64'd0);
        check("reset_busy", 64'(busy1), 64'd0);
        check("reset_finish", 64'(fin1), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(tv[i].sel, tv[i].mode, tv[i].a, tv[i].b, r, cyc, bcnt);
            check($sformatf("vec%0d_result", i), r, tv[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(cyc), 64'(tv[i].cyc));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(tv[i].cyc));
        end

        // Abort mid-CALC: result keeps the last completed value, finish never pulses.
        run_op(1, 1'b0, 32'd6, 32'd7, r, cyc, bcnt);
        check("abort_pre_result", r, 64'd42);
        mode32 = 1'b0; a32 = 32'd7; b32 = 32'd9; en1 = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1 en1 = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= fin1;
        end
        check("abort_no_finish", 64'(seen), 64'd0);
        check("abort_idle_busy", 64'(busy1), 64'd0);
        check("abort_result_kept", res1, 64'd42);
        run_op(1, 1'b0, 32'd100, 32'd200, r, cyc, bcnt);
        check("after_abort_result", r, 64'd20000);

        // Reset pulse mid-CALC clears every output at once.
        @(posedge clk); #1;
        mode32 = 1'b0; a32 = 32'd200; b32 = 32'd300; en1 = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_result", res1, 64'd0);
        check("midreset_busy", 64'(busy1), 64'd0);
        check("midreset_finish", 64'(fin1), 64'd0);
        check("midreset_result_d4", res4, 64'd0);
        check("midreset_result_d8", {48'b0, res8}, 64'd0);
        en1 = 1'b0;
        #2 rst_n = 1'b1;
        run_op(1, 1'b0, 32'd11, 32'd13, r, cyc, bcnt);
        check("after_reset_result", r, 64'd143);
        check("after_reset_latency", 64'(cyc), 64'd32);

        // Enable held through DONE: no retrigger, result stable, then a clean re-accept.
        @(posedge clk); #1;
        mode32 = 1'b0; a32 = 32'd9; b32 = 32'd9; en4 = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(posedge clk); #1;
            if (fin4) ok = 1'b1;
        end
        check("hold_finish_seen", 64'(ok), 64'd1);
        a32 = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        check("hold_finish_stays", 64'(fin4), 64'd1);
        check("hold_no_retrigger", 64'(busy4), 64'd0);
        check("hold_result_stable", res4, 64'd81);
        en4 = 1'b0;
        @(posedge clk); #1;
        check("drop_finish_low", 64'(fin4), 64'd0);
        check("drop_result_kept", res4, 64'd81);
        run_op(4, 1'b0, 32'd2, 32'd3, r, cyc, bcnt);
        check("reaccept_result", r, 64'd6);

        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 500; k++) begin
                logic [31:0] ra, rb;
                ra = $urandom;
                rb = $urandom;
                run_op(4, m[0], ra, rb, r, cyc, bcnt);
                check($sformatf("rand_m%0d_%0d a=%0h b=%0h", m, k, ra, rb), r,
                      ref32(m[0], ra, rb));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
